// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM state encoding and alignment check shared by the load/store unit.
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00) || size == 2'b11;
    endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [31:0] keep;
    logic [31:0] shifted;
    logic [31:0] ext;

    always_comb begin
        sh        = size == SZ_HALF ? {lane[1], 4'b0} : {lane, 3'b0};
        keep      = size == SZ_BYTE ? 32'h0000_00FF : size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        shifted   = word >> sh;
        ext       = size == SZ_BYTE ? {{24{sgn & shifted[7]}}, 8'h0} :
                    size == SZ_HALF ? {{16{sgn & shifted[15]}}, 16'h0} : 32'h0;
        load_data = (shifted & keep) | ext;
        merged    = (word & ~(keep << sh)) | ((wdata << sh) & (keep << sh));
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM in front of a word-addressed data memory.
// Sub-word stores read-modify-write the containing word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    output logic              memWrite,
    output logic              memRead,
    input  logic [31:0]       mem_read_data
);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       load_data, merged;
    logic              req_err;

    lsu_lane u_lane (
        .word     (mem_read_data),
        .lane     (addr_q[1:0]),
        .size     (size_q),
        .sgn      (signed_q),
        .wdata    (word_q),
        .load_data(load_data),
        .merged   (merged)
    );

    // word_q holds store data until READ, then the merged word (store) or the extended result (load)
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        err_d    = err_q;
        word_d   = word_q;
        req_err  = is_bad_req(req_size, req_addr[1:0]);
        if (state_q == ST_IDLE) begin
            if (req_valid) begin
                addr_d   = req_addr;
                size_d   = req_size;
                signed_d = req_signed;
                write_d  = req_write;
                err_d    = req_err;
                word_d   = req_wdata;
                state_d  = req_err ? ST_RESP : (req_write && req_size == SZ_WORD) ? ST_WRITE : ST_READ;
            end
        end else if (state_q == ST_READ) begin
            word_d  = write_q ? merged : load_data;
            state_d = write_q ? ST_WRITE : ST_RESP;
        end else begin
            state_d = state_q == ST_WRITE ? ST_RESP : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            err_q    <= err_d;
            word_q   <= word_d;
        end
    end

    assign req_ready      = state_q == ST_IDLE;
    assign memRead        = state_q == ST_READ;
    assign memWrite       = state_q == ST_WRITE;
    assign mem_address    = (memRead || memWrite) ? 32'(addr_q >> 2) : 32'h0;
    assign mem_write_data = memWrite ? word_q : 32'h0;
    assign resp_valid     = state_q == ST_RESP;
    assign resp_err       = resp_valid && err_q;
    assign resp_rdata     = (resp_valid && !err_q && !write_q) ? word_q : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed vectors plus reset-abort and back-to-back sequences.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wrn;
        logic [31:0] mem_exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, memWrite, memRead;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          total = 0;
    int          bad = 0;
    vec_t        vecs [16];

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .memWrite(memWrite), .memRead(memRead), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memWrite) begin
            mem[mem_address[3:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wdata;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int lat = 0, rd = 0, wr = 0;
        logic [31:0] rdata = '0;
        logic err = 1'b0;
        preload(v.addr[5:2], v.init);
        chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
        drive(v.wr, v.sz, v.sg, v.addr, v.wdata);
        @(negedge clk);
        // scramble the request lines: the unit must work from its registered copy
        req_valid = 1'b0; req_write = ~v.wr; req_size = ~v.sz; req_signed = ~v.sg;
        req_addr = ~v.addr; req_wdata = ~v.wdata;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) @(negedge clk);
            if (memRead) rd++;
            if (memWrite) wr++;
            if (memRead || memWrite)
                chk($sformatf("v%0d_maddr", i), mem_address, v.addr >> 2);
            if (resp_valid) begin
                lat = n; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        chk($sformatf("v%0d_latency", i), lat, v.lat);
        chk($sformatf("v%0d_rdata", i), rdata, v.rdata);
        chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, v.err});
        chk($sformatf("v%0d_reads", i), rd, v.rd);
        chk($sformatf("v%0d_writes", i), wr, v.wrn);
        @(negedge clk);
        chk($sformatf("v%0d_pulse", i), {31'b0, resp_valid}, 32'd0);
        chk($sformatf("v%0d_memword", i), mem[v.addr[5:2]], v.mem_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [3];
        int base, got;
        logic [31:0] exp_b2b [3];
        //            wr    size     sg    addr   wdata         init          rdata         err  lat rd wr mem
        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'd8,  32'd123,      32'h0,        32'h0,        1'b0, 2, 0, 1, 32'd123};
        vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'd9,  32'h0,        32'h8899AABB, 32'hFFFFFFAA, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'd9,  32'h0,        32'h8899AABB, 32'h000000AA, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[3]  = '{1'b1, SZ_HALF, 1'b0, 32'd10, 32'hDEAD1234, 32'h8899AABB, 32'h0,        1'b0, 3, 1, 1, 32'h1234AABB};
        vecs[4]  = '{1'b0, SZ_WORD, 1'b0, 32'd6,  32'h0,        32'h55555555, 32'h0,        1'b1, 1, 0, 0, 32'h55555555};
        vecs[5]  = '{1'b0, SZ_WORD, 1'b1, 32'd8,  32'h0,        32'h8899AABB, 32'h8899AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 32'd10, 32'h0,        32'h8899AABB, 32'hFFFF8899, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'd8,  32'h0,        32'h8899AABB, 32'h0000AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[8]  = '{1'b0, SZ_BYTE, 1'b1, 32'd11, 32'h0,        32'h7F000000, 32'h0000007F, 1'b0, 2, 1, 0, 32'h7F000000};
        vecs[9]  = '{1'b1, SZ_BYTE, 1'b0, 32'd13, 32'hFFFFFF55, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'h11225544};
        vecs[10] = '{1'b1, SZ_HALF, 1'b0, 32'd5,  32'h0000BEEF, 32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 0, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 2'b11,   1'b0, 32'd4,  32'h0,        32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 0, 32'hCAFEF00D};
        vecs[12] = '{1'b1, SZ_WORD, 1'b0, 32'd7,  32'h12345678, 32'h0BADF00D, 32'h0,        1'b1, 1, 0, 0, 32'h0BADF00D};
        vecs[13] = '{1'b0, SZ_BYTE, 1'b1, 32'd0,  32'h0,        32'h000000FF, 32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'h000000FF};
        vecs[14] = '{1'b0, SZ_HALF, 1'b1, 32'd2,  32'h0,        32'h7FFF8000, 32'h00007FFF, 1'b0, 2, 1, 0, 32'h7FFF8000};
        vecs[15] = '{1'b1, SZ_WORD, 1'b0, 32'd60, 32'hCAFEBABE, 32'h0,        32'h0,        1'b0, 2, 0, 1, 32'hCAFEBABE};

        rst_n = 1'b0;
        drive(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        req_valid = 1'b0;
        #3;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_strobes", {30'b0, memRead, memWrite}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // reset while a sub-word store is in READ: the write must never happen
        preload(4'd3, 32'hA5A5A5A5);
        drive(1'b1, SZ_BYTE, 1'b0, 32'd12, 32'h11);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_read", {31'b0, memRead}, 32'd1);
        base = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {30'b0, memRead, memWrite}, 32'd0);
        chk("abort_resp", {30'b0, resp_valid, resp_err}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk("abort_maddr", mem_address, 32'd0);
        chk("abort_mwdata", mem_write_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_no_write", wr_cnt - base, 32'd0);
        chk("abort_memword", mem[3], 32'hA5A5A5A5);

        // req_valid held high across three word loads
        exp_b2b[0] = 32'h01020304; exp_b2b[1] = 32'hA0B0C0D0; exp_b2b[2] = 32'h7E7E7E7E;
        for (int k = 0; k < 3; k++) preload(4'(4 + k), exp_b2b[k]);
        drive(1'b0, SZ_WORD, 1'b1, 32'd16, 32'h0);
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 8 && !req_ready; t++) @(negedge clk);
            chk($sformatf("b2b%0d_ready", k), {31'b0, req_ready}, 32'd1);
            req_addr = 32'(16 + 4 * k);
            @(negedge clk);
            acc[k] = cyc;
            if (k > 0) chk($sformatf("b2b%0d_spacing", k), acc[k] - acc[k-1], 32'd3);
            got = 0;
            for (int t = 0; t < 6; t++) begin
                if (resp_valid) begin
                    got = 1;
                    chk($sformatf("b2b%0d_rdata", k), resp_rdata, exp_b2b[k]);
                    chk($sformatf("b2b%0d_busy", k), {31'b0, req_ready}, 32'd0);
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("b2b%0d_resp_seen", k), got, 32'd1);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
